// File: rtl/speed_stepper.sv
// speed_stepper
//   Turns the 3-bit speed code from the divider chain into clk-synchronous
//   motion. The raw code is synchronised and de-glitched into "level". A step
//   timer then emits a one-cycle "step" pulse every (BASE_PERIOD >> level)
//   cycles, and each step advances a position counter for downstream logic.
//
// Ports
//   clk        in   1      system clock, rising edge
//   reset      in   1      asynchronous, active-low reset
//   speed_raw  in   3      speed code, asynchronous to clk, bits may skew
//   enable     in   1      1 = run step timer, 0 = pause (count is held)
//   load       in   1      one-cycle strobe: force pos to load_pos
//   load_pos   in   POS_W  position applied on load, clamped to POS_MAX
//   level      out  3      synchronised, filtered speed level
//   step       out  1      one-cycle pulse per elapsed step period
//   pos        out  POS_W  current position, 0..POS_MAX
//   wrap       out  1      one-cycle pulse with the step that wraps/reverses pos
//
// Configuration
//   SPEED_STEPPER_BOUNCE_EN : when defined, pos ping-pongs between 0 and
//   POS_MAX under an internal direction bit; otherwise pos wraps modulo
//   POS_MAX+1 and there is no direction state.

module speed_stepper #(
  parameter int CNT_W       = 24,
  parameter int BASE_PERIOD = 1_000_000,
  parameter int POS_W       = 4,
  parameter int POS_MAX     = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       speed_raw,
  input  logic             enable,
  input  logic             load,
  input  logic [POS_W-1:0] load_pos,
  output logic [2:0]       level,
  output logic             step,
  output logic [POS_W-1:0] pos,
  output logic             wrap
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] BASE_C    = CNT_W'(BASE_PERIOD);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [POS_W-1:0] POS_MAX_C = POS_W'(POS_MAX);
  localparam logic [POS_W-1:0] POS_ONE   = POS_W'(1);
  localparam logic [POS_W-1:0] POS_ZERO  = {POS_W{1'b0}};

  logic [2:0]       s1_q, s1_d, s2_q, s2_d, s2_dly_q, s2_dly_d;
  logic [2:0]       level_q, level_d;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             step_q, step_d;
  logic             wrap_q, wrap_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [CNT_W-1:0] period_raw_s, period_s, period_m1_s;
  logic             level_upd_s;
  logic             step_due_s;
`ifdef SPEED_STEPPER_BOUNCE_EN
  logic             dir_q, dir_d;   // 0 = counting up, 1 = counting down
`endif

  // Step period for the current level; levels that shift BASE_PERIOD to zero clamp to 1.
  always_comb begin
    period_raw_s = BASE_C >> level_q;
    if (period_raw_s == CNT_ZERO) begin
      period_s = CNT_ONE;
    end else begin
      period_s = period_raw_s;
    end
    period_m1_s = period_s - CNT_ONE;
  end

  // Next-state logic: synchroniser, level filter, step timer FSM and position.
  always_comb begin
    s1_d     = speed_raw;
    s2_d     = s1_q;
    s2_dly_d = s2_q;

    // Accept a new level only once s2 has held the same value for two samples.
    level_upd_s = (s2_q == s2_dly_q) && (s2_q != level_q);
    if (level_upd_s) begin
      level_d = s2_q;
    end else begin
      level_d = level_q;
    end

    state_d    = state_q;
    cnt_d      = cnt_q;
    step_due_s = 1'b0;
    step_d     = 1'b0;
    wrap_d     = 1'b0;
    pos_d      = pos_q;
`ifdef SPEED_STEPPER_BOUNCE_EN
    dir_d      = dir_q;
`endif

    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (!enable) begin
          // Pause keeps cnt so the period resumes where it stopped.
          state_d = IDLE;
        end else if (cnt_q >= period_m1_s) begin
          // ">=" also catches a period that shrank below the running count.
          step_due_s = 1'b1;
          cnt_d      = CNT_ZERO;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // load beats a level change, which beats a due step.
    if (load) begin
      cnt_d = CNT_ZERO;
      if (load_pos > POS_MAX_C) begin
        pos_d = POS_MAX_C;
      end else begin
        pos_d = load_pos;
      end
    end else if (level_upd_s) begin
      cnt_d = CNT_ZERO;
    end else if (step_due_s) begin
      step_d = 1'b1;
`ifdef SPEED_STEPPER_BOUNCE_EN
      if (!dir_q) begin
        if (pos_q >= POS_MAX_C) begin
          pos_d  = POS_MAX_C - POS_ONE;
          dir_d  = 1'b1;
          wrap_d = 1'b1;
        end else begin
          pos_d = pos_q + POS_ONE;
        end
      end else begin
        if (pos_q == POS_ZERO) begin
          pos_d  = POS_ONE;
          dir_d  = 1'b0;
          wrap_d = 1'b1;
        end else begin
          pos_d = pos_q - POS_ONE;
        end
      end
`else
      if (pos_q >= POS_MAX_C) begin
        pos_d  = POS_ZERO;
        wrap_d = 1'b1;
      end else begin
        pos_d = pos_q + POS_ONE;
      end
`endif
    end else begin
      cnt_d = cnt_d;
    end
  end

  // State registers; reset clears everything at once, so no step can trail it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q     <= 3'd0;
      s2_q     <= 3'd0;
      s2_dly_q <= 3'd0;
      level_q  <= 3'd0;
      state_q  <= IDLE;
      cnt_q    <= CNT_ZERO;
      step_q   <= 1'b0;
      wrap_q   <= 1'b0;
      pos_q    <= POS_ZERO;
`ifdef SPEED_STEPPER_BOUNCE_EN
      dir_q    <= 1'b0;
`endif
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      s2_dly_q <= s2_dly_d;
      level_q  <= level_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      step_q   <= step_d;
      wrap_q   <= wrap_d;
      pos_q    <= pos_d;
`ifdef SPEED_STEPPER_BOUNCE_EN
      dir_q    <= dir_d;
`endif
    end
  end

  assign level = level_q;
  assign step  = step_q;
  assign pos   = pos_q;
  assign wrap  = wrap_q;

endmodule
